umbral_control: RTL and testbench

- Upstream stage that produces the 12-bit threshold word consumed by the PWM comparator stage on its `i_umbral` input.
- Converts two raw push-button levels (up/down) into a saturating threshold value. Internal steps: synchronization, debounce, single-step on press, auto-repeat on hold.
- Also supports a direct parallel load.
- Output is registered and changes at most once per clock.

---
 rtl/umbral_control_if.sv | 22 ++
 rtl/umbral_control.sv | 163 ++++++++++++++++
 tb/tb_umbral_control.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/umbral_control_if.sv
// umbral_control_if: button levels, parallel load and threshold/status outputs of umbral_control.
// master drives the buttons and load; slave is the threshold generator.
interface umbral_control_if;
  logic        i_up;
  logic        i_down;
  logic        i_load;
  logic [11:0] i_load_val;
  logic [11:0] o_umbral;
  logic        o_step;
  logic        o_at_max;
  logic        o_at_min;

  modport master (
    output i_up, i_down, i_load, i_load_val,
    input  o_umbral, o_step, o_at_max, o_at_min
  );

  modport slave (
    input  i_up, i_down, i_load, i_load_val,
    output o_umbral, o_step, o_at_max, o_at_min
  );
endinterface

// File: rtl/umbral_control.sv
// umbral_control: debounced up/down buttons with auto-repeat drive a 12-bit threshold word.
// Saturating by default; define UMBRAL_WRAP_EN for modulo-4096 stepping.
module umbral_control #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_DELAY    = 64,
  parameter int unsigned REPEAT_RATE     = 8,
  parameter int unsigned STEP            = 16,
  parameter int unsigned INIT            = 2048
) (
  input  logic             clock,
  input  logic             reset,
  umbral_control_if.slave  bus
);
  typedef enum logic [1:0] {StIdle, StHold, StRepeat} state_e;

  localparam logic [19:0] DebLast   = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic [19:0] DelayLast = 20'(REPEAT_DELAY - 1);
  localparam logic [19:0] RateLast  = 20'(REPEAT_RATE - 1);
  localparam logic [12:0] Step13    = 13'(STEP);
  localparam logic [11:0] Init12    = 12'(INIT);
  localparam logic [11:0] Max12     = 12'hfff;

  // Bit 0 is the up button, bit 1 the down button.
  logic [1:0]  raw, sync1_q, sync2_q;
  logic [1:0]  deb_q, deb_d, deb_prev_q, rise, fall;
  logic [1:0]  req_d, req_q;
  logic        both;
  logic [19:0] cnt_q [2];
  logic [19:0] cnt_d [2];
  logic [19:0] timer_q [2];
  logic [19:0] timer_d [2];
  state_e      state_q [2];
  state_e      state_d [2];

  logic [11:0] umbral_q, umbral_d;
  logic        step_q, step_d, at_max_q, at_min_q;
  logic [12:0] sum, diff;

  assign raw  = {bus.i_down, bus.i_up};
  assign both = &deb_q;
  assign rise = deb_q & ~deb_prev_q;
  assign fall = ~deb_q & deb_prev_q;

  always_comb begin
    deb_d = deb_q;
    cnt_d = '{default: '0};
    for (int b = 0; b < 2; b++) begin
      if (sync2_q[b] != deb_q[b]) begin
        if (cnt_q[b] == DebLast) begin
          deb_d[b] = ~deb_q[b];
        end else begin
          cnt_d[b] = cnt_q[b] + 20'd1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    req_d   = '0;
    for (int b = 0; b < 2; b++) begin
      if (fall[b]) begin
        state_d[b] = StIdle;
        timer_d[b] = '0;
      end else if (both) begin
        // Both held: park at the start of HOLD so the survivor restarts its delay silently.
        if (state_q[b] != StIdle || rise[b]) state_d[b] = StHold;
        timer_d[b] = '0;
      end else begin
        unique case (state_q[b])
          StIdle: begin
            if (rise[b]) begin
              state_d[b] = StHold;
              timer_d[b] = '0;
              req_d[b]   = 1'b1;
            end
          end
          StHold: begin
            if (timer_q[b] == DelayLast) begin
              state_d[b] = StRepeat;
              timer_d[b] = '0;
              req_d[b]   = 1'b1;
            end else begin
              timer_d[b] = timer_q[b] + 20'd1;
            end
          end
          StRepeat: begin
            if (timer_q[b] == RateLast) begin
              timer_d[b] = '0;
              req_d[b]   = 1'b1;
            end else begin
              timer_d[b] = timer_q[b] + 20'd1;
            end
          end
          default: state_d[b] = StIdle;
        endcase
      end
    end
  end

  always_comb begin
    sum      = {1'b0, umbral_q} + Step13;
    diff     = {1'b0, umbral_q} - Step13;
    umbral_d = umbral_q;
    step_d   = 1'b0;
    if (bus.i_load) begin
      umbral_d = bus.i_load_val;
    end else if (req_q[0]) begin
`ifdef UMBRAL_WRAP_EN
      umbral_d = sum[11:0];
      step_d   = 1'b1;
`else
      umbral_d = sum[12] ? Max12 : sum[11:0];
      step_d   = (umbral_q != Max12);
`endif
    end else if (req_q[1]) begin
`ifdef UMBRAL_WRAP_EN
      umbral_d = diff[11:0];
      step_d   = 1'b1;
`else
      // diff[12] is the borrow: the subtraction went below zero.
      umbral_d = diff[12] ? 12'd0 : diff[11:0];
      step_d   = (umbral_q != 12'd0);
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      cnt_q      <= '{default: '0};
      timer_q    <= '{default: '0};
      state_q    <= '{default: StIdle};
      req_q      <= '0;
      umbral_q   <= Init12;
      step_q     <= 1'b0;
      at_max_q   <= (Init12 == Max12);
      at_min_q   <= (Init12 == 12'd0);
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      cnt_q      <= cnt_d;
      timer_q    <= timer_d;
      state_q    <= state_d;
      req_q      <= req_d;
      umbral_q   <= umbral_d;
      step_q     <= step_d;
      at_max_q   <= (umbral_d == Max12);
      at_min_q   <= (umbral_d == 12'd0);
    end
  end

  assign bus.o_umbral = umbral_q;
  assign bus.o_step   = step_q;
  assign bus.o_at_max = at_max_q;
  assign bus.o_at_min = at_min_q;
endmodule

// File: tb/tb_umbral_control.sv
// tb_umbral_control: random and directed button/load stimulus; a timing-level reference model
// predicts every threshold change and a negedge monitor scores the DUT against it.
module tb_umbral_control;
  localparam int DEB  = 16;
  localparam int RD   = 64;
  localparam int RR   = 8;
  localparam int STEP = 16;
  localparam int INIT = 2048;

  logic clock;
  logic reset = 1'b1;
  umbral_control_if bus ();

  umbral_control #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR),
    .STEP           (STEP),
    .INIT           (INIT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int u;
    bit st;
  } exp_t;
  exp_t sb[$];

  // Reference model: raw samples reach the debouncer two edges late, a debounced level flips
  // after DEB consecutive disagreeing samples, and steps are scheduled by elapsed time since
  // the press was (re)anchored; a request takes effect one edge later.
  int edge_n   = 0;
  bit rst_edge = 1'b1;
  int m_u      = INIT;
  int m_preq   = 0;
  bit m_r1 [2];
  bit m_r2 [2];
  bit m_d  [2];
  bit m_dp [2];
  bit m_act[2];
  int m_run[2];
  int m_anchor[2];
  int nu, el;
  bit st, both, rise, fall;
  bit req [2];

  always @(posedge clock) begin
    edge_n++;
    if (reset) begin
      rst_edge = 1'b1;
      m_u      = INIT;
      m_preq   = 0;
      for (int b = 0; b < 2; b++) begin
        m_r1[b] = 0; m_r2[b] = 0; m_d[b] = 0; m_dp[b] = 0;
        m_act[b] = 0; m_run[b] = 0; m_anchor[b] = 0;
      end
    end else begin
      rst_edge = 1'b0;
      nu = m_u;
      st = 1'b0;
      if (bus.i_load) begin
        nu = int'(bus.i_load_val);
      end else if (m_preq == 1) begin
`ifdef UMBRAL_WRAP_EN
        nu = (m_u + STEP) % 4096;
        st = 1'b1;
`else
        nu = (m_u + STEP > 4095) ? 4095 : m_u + STEP;
        st = (nu != m_u);
`endif
      end else if (m_preq == 2) begin
`ifdef UMBRAL_WRAP_EN
        nu = (m_u + 4096 - STEP) % 4096;
        st = 1'b1;
`else
        nu = (m_u - STEP < 0) ? 0 : m_u - STEP;
        st = (nu != m_u);
`endif
      end
      if (st || nu != m_u) sb.push_back('{u: nu, st: st});
      m_u = nu;

      both = m_d[0] && m_d[1];
      for (int b = 0; b < 2; b++) begin
        rise   = m_d[b] && !m_dp[b];
        fall   = !m_d[b] && m_dp[b];
        req[b] = 1'b0;
        if (fall) begin
          m_act[b] = 1'b0;
        end else if (both) begin
          if (m_act[b] || rise) begin
            m_act[b]    = 1'b1;
            m_anchor[b] = edge_n;
          end
        end else if (rise) begin
          m_act[b]    = 1'b1;
          m_anchor[b] = edge_n;
          req[b]      = 1'b1;
        end else if (m_act[b]) begin
          el     = edge_n - m_anchor[b];
          req[b] = (el == RD) || (el > RD && (el - RD) % RR == 0);
        end
      end
      m_preq = req[0] ? 1 : (req[1] ? 2 : 0);

      for (int b = 0; b < 2; b++) begin
        m_dp[b] = m_d[b];
        if (m_r2[b] != m_d[b]) begin
          m_run[b]++;
          if (m_run[b] == DEB) begin
            m_d[b]   = !m_d[b];
            m_run[b] = 0;
          end
        end else begin
          m_run[b] = 0;
        end
        m_r2[b] = m_r1[b];
      end
      m_r1[0] = bus.i_up;
      m_r1[1] = bus.i_down;
    end
  end

  // Monitor: any o_step pulse or o_umbral change must match the next queued prediction.
  int   last_u = INIT;
  bit   ev, exp_ev;
  exp_t e;

  always @(negedge clock) begin
    if (rst_edge) begin
      last_u = int'(bus.o_umbral);
    end else begin
      ev     = bus.o_step || (int'(bus.o_umbral) != last_u);
      exp_ev = (sb.size() != 0);
      if (ev || exp_ev) begin
        chk("event_present", int'(ev), int'(exp_ev));
        if (ev && exp_ev) begin
          e = sb.pop_front();
          chk("umbral", int'(bus.o_umbral), e.u);
          chk("step", int'(bus.o_step), int'(e.st));
          chk("at_max", int'(bus.o_at_max), int'(e.u == 4095));
          chk("at_min", int'(bus.o_at_min), int'(e.u == 0));
        end
        sb.delete();
      end
      last_u = int'(bus.o_umbral);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_umbral"}, int'(bus.o_umbral), INIT);
    chk({tag, "_step"}, int'(bus.o_step), 0);
    chk({tag, "_at_max"}, int'(bus.o_at_max), int'(INIT == 4095));
    chk({tag, "_at_min"}, int'(bus.o_at_min), int'(INIT == 0));
  endtask

  task automatic press(input bit up, input int hold);
    if (up) bus.i_up = 1'b1;
    else    bus.i_down = 1'b1;
    cyc(hold);
    bus.i_up   = 1'b0;
    bus.i_down = 1'b0;
    cyc(40);
  endtask

  int lat;
  int len;

  initial begin
    bus.i_up       = 1'b0;
    bus.i_down     = 1'b0;
    bus.i_load     = 1'b0;
    bus.i_load_val = '0;
    cyc(3);
    reset = 1'b0;
    check_reset_state("reset");
    cyc(20);
    check_reset_state("idle");

    // Clean press: first change lands 3+DEB edges after the first sampling edge.
    bus.i_up = 1'b1;
    lat = 40;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock);
      #1;
      if (int'(bus.o_umbral) != INIT) begin
        lat = k;
        break;
      end
    end
    chk("press_latency", lat, 3 + DEB);
    cyc(12);
    bus.i_up = 1'b0;
    cyc(40);
    chk("clean_press", int'(bus.o_umbral), INIT + STEP);

    // Bouncing contact: toggles every 5 cycles never qualify; the final hold gives one step.
    for (int i = 0; i < 8; i++) begin
      bus.i_up = ~bus.i_up;
      cyc(5);
    end
    press(1'b1, 30);
    chk("bounce_press", int'(bus.o_umbral), INIT + 2 * STEP);

    // Long down hold: 1 press step + 1 after RD + 19 repeats before the release is debounced.
    press(1'b0, 3 + DEB + 200);
    chk("down_hold", int'(bus.o_umbral), INIT + 2 * STEP - 21 * STEP);

    // Load near the top, then saturate (or wrap).
    bus.i_load = 1'b1; bus.i_load_val = 12'd4090;
    cyc(1);
    bus.i_load = 1'b0;
    chk("load_4090", int'(bus.o_umbral), 4090);
    press(1'b1, 30);
`ifdef UMBRAL_WRAP_EN
    chk("up_from_4090", int'(bus.o_umbral), 10);
    press(1'b1, 30);
    chk("up_again", int'(bus.o_umbral), 26);
`else
    chk("up_from_4090", int'(bus.o_umbral), 4095);
    chk("at_max_set", int'(bus.o_at_max), 1);
    press(1'b1, 30);
    chk("up_saturated", int'(bus.o_umbral), 4095);
`endif

    // Load near the bottom, then saturate (or wrap).
    bus.i_load = 1'b1; bus.i_load_val = 12'd5;
    cyc(1);
    bus.i_load = 1'b0;
    press(1'b0, 30);
`ifdef UMBRAL_WRAP_EN
    chk("down_from_5", int'(bus.o_umbral), 4085);
`else
    chk("down_from_5", int'(bus.o_umbral), 0);
    chk("at_min_set", int'(bus.o_at_min), 1);
    press(1'b0, 30);
    chk("down_saturated", int'(bus.o_umbral), 0);
`endif

    // Up in REPEAT, down joins then leaves, then reset mid-hold; button stays held afterwards.
    bus.i_up = 1'b1;
    cyc(110);
    bus.i_down = 1'b1;
    cyc(100);
    bus.i_down = 1'b0;
    cyc(100);
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    check_reset_state("mid_hold_reset");
    cyc(40);
    bus.i_up = 1'b0;
    cyc(40);

    // Random segments: held levels, glitches, loads biased to the limits, occasional reset.
    for (int seg = 0; seg < 50; seg++) begin
      bus.i_up   = ($urandom_range(0, 2) == 0);
      bus.i_down = ($urandom_range(0, 3) == 0);
      len = int'($urandom_range(5, 160));
      for (int c = 0; c < len; c++) begin
        bus.i_load = ($urandom_range(0, 60) == 0);
        case ($urandom_range(0, 3))
          0:       bus.i_load_val = 12'd0;
          1:       bus.i_load_val = 12'd4095;
          default: bus.i_load_val = 12'($urandom_range(0, 4095));
        endcase
        if ($urandom_range(0, 30) == 0) bus.i_up = ~bus.i_up;
        if ($urandom_range(0, 40) == 0) bus.i_down = ~bus.i_down;
        cyc(1);
      end
      bus.i_load = 1'b0;
      if ($urandom_range(0, 15) == 0) begin
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        check_reset_state("random_reset");
      end
    end

    bus.i_up   = 1'b0;
    bus.i_down = 1'b0;
    bus.i_load = 1'b0;
    cyc(60);
    chk("final_umbral", int'(bus.o_umbral), m_u);
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
